// File: rtl/intra4x4_sad_mode_decide_pkg.sv
// Shared constants and types for the intra 4x4 SAD mode decision block.
// Holds pixel/block/SAD/mode widths, the default mode count and the
// controller state enumeration.
package intra4x4_sad_mode_decide_pkg;

    localparam int PIX_W         = 8;
    localparam int BLK_PIX       = 16;
    localparam int BLK_W         = PIX_W * BLK_PIX;
    localparam int SAD_W         = 12;
    localparam int MODE_W        = 6;
    localparam int NUM_MODES_DEF = 35;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/intra4x4_sad_mode_decide_sad4x4_tree.sv
// sad4x4_tree: two-stage pipelined SAD of a 4x4 prediction block against an
// original block. Stage 1 registers 16 absolute differences, stage 2
// registers their 12-bit sum. Valid, mode and last-beat tags travel with
// the data.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (valids only)
//   clr_i          discards in-flight beats (clears both valids)
//   vld_i          a beat enters this cycle
//   last_i         beat is the final one of the PU
//   mode_i         mode tag of the beat
//   pred_i/orig_i  packed 4x4 blocks, pixel i at [DATA_W*i +: DATA_W]
//   vld_o/last_o/mode_o/sad_o  stage-2 outputs
module sad4x4_tree
    import intra4x4_sad_mode_decide_pkg::*;
#(
    parameter int DATA_W = PIX_W
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clr_i,
    input  logic                        vld_i,
    input  logic                        last_i,
    input  logic [MODE_W-1:0]           mode_i,
    input  logic [BLK_PIX*DATA_W-1:0]   pred_i,
    input  logic [BLK_PIX*DATA_W-1:0]   orig_i,
    output logic                        vld_o,
    output logic                        last_o,
    output logic [MODE_W-1:0]           mode_o,
    output logic [SAD_W-1:0]            sad_o
);

    function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic signed [DATA_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        if (d < 0) d = -d;
        return d[DATA_W-1:0];
    endfunction

    // Sixteen 8-bit terms never exceed 4080, so a 12-bit accumulator cannot wrap.
    function automatic logic [SAD_W-1:0] sad_sum(input logic [BLK_PIX*DATA_W-1:0] v);
        logic [SAD_W-1:0] s;
        s = '0;
        for (int i = 0; i < BLK_PIX; i++)
            s = s + {{(SAD_W-DATA_W){1'b0}}, v[i*DATA_W +: DATA_W]};
        return s;
    endfunction

    logic [BLK_PIX*DATA_W-1:0] ad_p1;
    logic [MODE_W-1:0]         mode_p1;
    logic                      last_p1;
    logic                      vld_p1;

    logic [SAD_W-1:0]          sad_p2;
    logic [MODE_W-1:0]         mode_p2;
    logic                      last_p2;
    logic                      vld_p2;

    // Stage 1: absolute differences
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) vld_p1 <= 1'b0;
        else                vld_p1 <= vld_i;
    end

    always_ff @(posedge clk_i) begin
        if (vld_i) begin
            for (int i = 0; i < BLK_PIX; i++)
                ad_p1[i*DATA_W +: DATA_W] <= abs_diff(pred_i[i*DATA_W +: DATA_W],
                                                      orig_i[i*DATA_W +: DATA_W]);
            mode_p1 <= mode_i;
            last_p1 <= last_i;
        end
    end

    // Stage 2: adder tree
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) vld_p2 <= 1'b0;
        else                vld_p2 <= vld_p1;
    end

    always_ff @(posedge clk_i) begin
        if (vld_p1) begin
            sad_p2  <= sad_sum(ad_p1);
            mode_p2 <= mode_p1;
            last_p2 <= last_p1;
        end
    end

    assign vld_o  = vld_p2;
    assign last_o = last_p2;
    assign mode_o = mode_p2;
    assign sad_o  = sad_p2;

endmodule

// File: rtl/intra4x4_sad_mode_decide.sv
// intra4x4_sad_mode_decide: evaluates NUM_MODES prediction blocks per PU
// against a latched original 4x4 block and reports the mode with minimum SAD.
// Ports:
//   CLK_LOW     block clock
//   RST         synchronous active-high reset
//   START       pulse: latch ORIG_BLK, begin (or restart) a PU evaluation
//   ORIG_BLK    original 4x4 block, row-major, 8 bits per pixel
//   PRED_VALID  PRED_BLK/PRED_MODE carry a beat this cycle
//   PRED_MODE   intra mode tag of the beat
//   PRED_BLK    prediction block, same packing as ORIG_BLK
//   BUSY        evaluation in progress
//   DONE        one-cycle pulse, BEST_MODE/BEST_SAD final
//   BEST_MODE   mode with minimum SAD (earliest wins ties)
//   BEST_SAD    minimum SAD
module intra4x4_sad_mode_decide
    import intra4x4_sad_mode_decide_pkg::*;
#(
    parameter int NUM_MODES = NUM_MODES_DEF
) (
    input  logic              CLK_LOW,
    input  logic              RST,
    input  logic              START,
    input  logic [BLK_W-1:0]  ORIG_BLK,
    input  logic              PRED_VALID,
    input  logic [MODE_W-1:0] PRED_MODE,
    input  logic [BLK_W-1:0]  PRED_BLK,
    output logic              BUSY,
    output logic              DONE,
    output logic [MODE_W-1:0] BEST_MODE,
    output logic [SAD_W-1:0]  BEST_SAD
);

    localparam logic [MODE_W-1:0] LAST_CNT = MODE_W'(NUM_MODES);

    state_e            state_q;
    logic [MODE_W-1:0] cnt_q;
    logic [BLK_W-1:0]  orig_q;
    logic              best_vld_q;
    logic [MODE_W-1:0] best_mode_q;
    logic [SAD_W-1:0]  best_sad_q;
    logic              busy_q;
    logic              done_q;

    logic              beat_d;
    logic              last_d;
    logic              upd_d;

    logic              sad_vld;
    logic              sad_last;
    logic [MODE_W-1:0] sad_mode;
    logic [SAD_W-1:0]  sad_val;

    // START outranks a coincident beat, so that beat never reaches the tree.
    assign beat_d = (state_q == ST_ACCUM) && PRED_VALID && !START;
    assign last_d = (cnt_q + 1'b1) == LAST_CNT;
    assign upd_d  = sad_vld && (!best_vld_q || (sad_val < best_sad_q));

    always_ff @(posedge CLK_LOW) begin
        if (START) orig_q <= ORIG_BLK;
    end

    sad4x4_tree #(
        .DATA_W (PIX_W)
    ) u_tree (
        .clk_i  (CLK_LOW),
        .rst_i  (RST),
        .clr_i  (START),
        .vld_i  (beat_d),
        .last_i (last_d),
        .mode_i (PRED_MODE),
        .pred_i (PRED_BLK),
        .orig_i (orig_q),
        .vld_o  (sad_vld),
        .last_o (sad_last),
        .mode_o (sad_mode),
        .sad_o  (sad_val)
    );

    // Compare stage: controller and minimum tracker
    always_ff @(posedge CLK_LOW) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            best_vld_q  <= 1'b0;
            best_mode_q <= '0;
            best_sad_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (START) begin
            // Best results are deliberately kept until the new PU's first compare.
            state_q    <= ST_ACCUM;
            cnt_q      <= '0;
            best_vld_q <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (upd_d) begin
                best_vld_q  <= 1'b1;
                best_mode_q <= sad_mode;
                best_sad_q  <= sad_val;
            end
            unique case (state_q)
                ST_ACCUM: begin
                    if (beat_d) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_d) state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // DONE rides the final compare; the following edge leaves FLUSH.
                    if (done_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (sad_vld && sad_last) begin
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign BEST_MODE = best_mode_q;
    assign BEST_SAD  = best_sad_q;

endmodule

// File: tb/tb_intra4x4_sad_mode_decide.sv
module tb_intra4x4_sad_mode_decide;
    import intra4x4_sad_mode_decide_pkg::*;

    localparam int NM = 35;

    logic              CLK_LOW = 1'b0;
    logic              RST = 1'b0;
    logic              START = 1'b0;
    logic [BLK_W-1:0]  ORIG_BLK = '0;
    logic              PRED_VALID = 1'b0;
    logic [MODE_W-1:0] PRED_MODE = '0;
    logic [BLK_W-1:0]  PRED_BLK = '0;
    logic              BUSY;
    logic              DONE;
    logic [MODE_W-1:0] BEST_MODE;
    logic [SAD_W-1:0]  BEST_SAD;

    intra4x4_sad_mode_decide #(.NUM_MODES(NM)) dut (
        .CLK_LOW    (CLK_LOW),
        .RST        (RST),
        .START      (START),
        .ORIG_BLK   (ORIG_BLK),
        .PRED_VALID (PRED_VALID),
        .PRED_MODE  (PRED_MODE),
        .PRED_BLK   (PRED_BLK),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .BEST_MODE  (BEST_MODE),
        .BEST_SAD   (BEST_SAD)
    );

    always #5 CLK_LOW = ~CLK_LOW;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [BLK_W-1:0] fill(input int v);
        logic [BLK_W-1:0] b;
        for (int i = 0; i < BLK_PIX; i++) b[i*8 +: 8] = 8'(v);
        return b;
    endfunction

    function automatic int ref_sad(input logic [BLK_W-1:0] p, input logic [BLK_W-1:0] o);
        int s;
        int a;
        int b;
        s = 0;
        for (int i = 0; i < BLK_PIX; i++) begin
            a = int'(p[i*8 +: 8]);
            b = int'(o[i*8 +: 8]);
            s += (a > b) ? a - b : b - a;
        end
        return s;
    endfunction

    // Behavioural model: tracks PUs as lists of accepted beats whose results
    // land two edges after acceptance.
    typedef struct {
        int due;
        int sad;
        int mode;
    } cmp_t;

    cmp_t             pend[$];
    int               cyc = 0;
    bit               mv = 0;
    bit               m_accepting = 0;
    bit               m_busy = 0;
    bit               m_done = 0;
    bit               m_best_vld = 0;
    int               m_best_mode = 0;
    int               m_best_sad = 0;
    int               m_cnt = 0;
    int               done_due = -1;
    logic [BLK_W-1:0] m_orig = '0;

    always @(posedge CLK_LOW) begin
        cyc++;
        m_done = 0;
        if (RST) begin
            mv = 1;
            m_accepting = 0;
            m_busy = 0;
            m_best_vld = 0;
            m_best_mode = 0;
            m_best_sad = 0;
            m_cnt = 0;
            done_due = -1;
            pend.delete();
        end else if (START) begin
            pend.delete();
            m_orig = ORIG_BLK;
            m_cnt = 0;
            m_best_vld = 0;
            m_busy = 1;
            m_accepting = 1;
            done_due = -1;
        end else begin
            while (pend.size() > 0 && pend[0].due == cyc) begin
                if (!m_best_vld || pend[0].sad < m_best_sad) begin
                    m_best_vld = 1;
                    m_best_sad = pend[0].sad;
                    m_best_mode = pend[0].mode;
                end
                void'(pend.pop_front());
            end
            if (done_due >= 0 && cyc == done_due) m_done = 1;
            if (done_due >= 0 && cyc == done_due + 1) begin
                m_busy = 0;
                done_due = -1;
            end
            if (m_accepting && PRED_VALID) begin
                pend.push_back('{cyc + 2, ref_sad(PRED_BLK, m_orig), int'(PRED_MODE)});
                m_cnt++;
                if (m_cnt == NM) begin
                    m_accepting = 0;
                    done_due = cyc + 2;
                end
            end
        end
    end

    int done_cnt = 0;
    int done_cyc = 0;

    always @(negedge CLK_LOW) begin
        if (mv) begin
            chk("busy", BUSY, m_busy);
            chk("done", DONE, m_done);
            chk("best_mode", BEST_MODE, m_best_mode);
            chk("best_sad", BEST_SAD, m_best_sad);
            if (DONE === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    int last_e = 0;

    task automatic drive(input bit st, input logic [BLK_W-1:0] o, input bit pv,
                         input int mode, input logic [BLK_W-1:0] b);
        @(negedge CLK_LOW);
        START = st;
        ORIG_BLK = o;
        PRED_VALID = pv;
        PRED_MODE = 6'(mode);
        PRED_BLK = b;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, ORIG_BLK, 0, 0, '0);
    endtask

    task automatic beat(input int mode, input logic [BLK_W-1:0] b);
        drive(0, ORIG_BLK, 1, mode, b);
        last_e = cyc + 1;
    endtask

    task automatic do_reset(input int n);
        @(negedge CLK_LOW);
        RST = 1'b1;
        START = 1'b0;
        PRED_VALID = 1'b0;
        repeat (n) @(negedge CLK_LOW);
        RST = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            idle(1);
            #1;
            if (done_cnt > d0) seen = 1;
        end
        chk({name, "_done_seen"}, seen, 1);
        if (seen) chk({name, "_done_latency"}, done_cyc - last_e, 2);
    endtask

    task automatic run_min(input string name, input bit gapped);
        drive(1, fill(80), 0, 0, '0);
        for (int m = 0; m < NM; m++) begin
            if (gapped && m > 0) idle($urandom_range(0, 3));
            beat(m, fill(60 + m));
        end
        wait_done(name, 10);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d0;

        // Reset values
        do_reset(2);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_best_mode", BEST_MODE, 0);
        chk("rst_best_sad", BEST_SAD, 0);

        // Beats while idle are ignored
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) drive(0, '0, 1, 5, fill(9));
        idle(4);
        chk("idle_busy", BUSY, 0);
        chk("idle_done_cnt", done_cnt - d0, 0);
        chk("idle_best_sad", BEST_SAD, 0);

        // Minimum search, back-to-back
        d0 = done_cnt;
        run_min("min", 0);
        chk("min_best_mode", BEST_MODE, 20);
        chk("min_best_sad", BEST_SAD, 0);
        idle(4);
        chk("min_busy_after", BUSY, 0);
        chk("min_done_cnt", done_cnt - d0, 1);

        // Tie: earliest mode wins
        drive(1, fill(0), 0, 0, '0);
        beat(7, fill(5));
        for (int m = 0; m < NM; m++) if (m != 7) beat(m, fill(5));
        wait_done("tie", 10);
        chk("tie_best_mode", BEST_MODE, 7);
        chk("tie_best_sad", BEST_SAD, 80);
        idle(3);

        // Width extreme
        drive(1, fill(0), 0, 0, '0);
        for (int i = 0; i < NM; i++) beat((12 + i) % NM, fill(255));
        wait_done("wide", 10);
        chk("wide_best_mode", BEST_MODE, 12);
        chk("wide_best_sad", BEST_SAD, 4080);
        idle(3);

        // Gapped input, then beats after DONE ignored
        d0 = done_cnt;
        run_min("gap", 1);
        chk("gap_best_mode", BEST_MODE, 20);
        chk("gap_best_sad", BEST_SAD, 0);
        for (int i = 0; i < 3; i++) drive(0, ORIG_BLK, 1, 50, fill(80));
        idle(5);
        chk("gap_post_mode", BEST_MODE, 20);
        chk("gap_post_busy", BUSY, 0);
        chk("gap_done_cnt", done_cnt - d0, 1);

        // Abort with in-flight beats; START coincides with a beat that must drop
        d0 = done_cnt;
        drive(1, fill(100), 0, 0, '0);
        for (int m = 0; m < 10; m++) beat(m, fill(100));
        drive(1, fill(200), 1, 40, fill(200));
        for (int m = 0; m < NM; m++) beat(m, fill(m == 3 ? 200 : 10));
        wait_done("abort", 10);
        idle(5);
        chk("abort_done_cnt", done_cnt - d0, 1);
        chk("abort_best_mode", BEST_MODE, 3);
        chk("abort_best_sad", BEST_SAD, 0);

        // Reset mid-ACCUM
        d0 = done_cnt;
        drive(1, fill(0), 0, 0, '0);
        for (int m = 0; m < 5; m++) beat(9 + m, fill(7));
        idle(3);
        chk("mid_pre_mode", BEST_MODE, 9);
        chk("mid_pre_sad", BEST_SAD, 112);
        do_reset(1);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_done", DONE, 0);
        chk("mid_rst_mode", BEST_MODE, 0);
        chk("mid_rst_sad", BEST_SAD, 0);
        idle(10);
        chk("mid_done_cnt", done_cnt - d0, 0);
        chk("mid_busy_after", BUSY, 0);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/intra4x4_sad_mode_decide.md
# intra4x4_sad_mode_decide

Downstream of the DC/angular prediction output selector. Consumes one registered 4x4 prediction block per valid cycle, each tagged with its intra mode index. Computes the SAD of each block against a latched 4x4 original block and tracks the running minimum. When the configured number of modes has been evaluated, it reports the best mode and its SAD to the PU controller.

## Interface
- NUM_MODES, 35, number of prediction blocks evaluated per PU (valid range 1..63)
- CLK_LOW  in  1  block clock, the same low-rate clock that drives the prediction output selector
- RST  in  1  synchronous, active-high reset
- START  in  1  single-cycle pulse; latches ORIG_BLK and begins a new PU evaluation
- ORIG_BLK  in  128  original 4x4 pixels, row-major; pixel (r,c), r,c in 0..3, at bits [8*(4r+c)+7 : 8*(4r+c)]
- PRED_VALID  in  1  PRED_BLK/PRED_MODE carry a prediction this cycle
- PRED_MODE  in  6  intra mode index of PRED_BLK
- PRED_BLK  in  128  prediction block, same packing as ORIG_BLK (the 16 selector outputs PRED_OUT11..44 concatenated)
- BUSY  out  1  evaluation in progress
- DONE  out  1  one-cycle pulse; BEST_MODE/BEST_SAD are final
- BEST_MODE  out  6  mode with minimum SAD
- BEST_SAD  out  12  minimum SAD, range 0..4080

## Operation
- States:
  - IDLE: waits for START.
  - ACCUM: accepts beats until NUM_MODES beats have been accepted.
  - FLUSH: drains the 2-stage SAD pipeline.
  - Reporting returns to IDLE.
- START in any state:
  - Latches ORIG_BLK and clears the accepted-beat counter, the best-valid flag and the pipeline valids.
  - Enters ACCUM.
  - A START in ACCUM/FLUSH aborts the current PU. In-flight beats are discarded and no DONE is produced for the aborted PU.
- START and PRED_VALID in the same cycle: START wins and that beat is dropped.
- PRED_VALID is ignored outside ACCUM. There is no backpressure; every beat in ACCUM is accepted.
- Beat counter: 6 bits. After accepting beat NUM_MODES, ACCUM goes to FLUSH and further PRED_VALID is ignored.
- Stage 1: 16 absolute differences |PRED-ORIG|, each 8 bits unsigned, registered together with the mode and valid bits.
- Stage 2: adder tree to a 12-bit sum (max 16*255 = 4080, no overflow), registered.
- Compare: if best-valid is 0 or sum < best SAD (strict), update BEST_SAD/BEST_MODE and set best-valid. On ties the earliest-arriving mode is kept.
- FLUSH ends when the last beat's compare has been applied. DONE is then pulsed and the state returns to IDLE.
- BEST_MODE/BEST_SAD hold their values from DONE until the first compare update of the next PU. They are not cleared at START.
- PRED_MODE is carried unchecked; values above 34 are treated as ordinary tags.

## Timing
- Reset values: BUSY=0, DONE=0, BEST_MODE=0, BEST_SAD=0; state IDLE; all pipeline valids 0.
- START sampled at edge t: BUSY=1 after edge t. The first beat can be accepted at edge t+1.
- Beat accepted at edge e:
  - abs diffs registered at e;
  - sum registered at e+1;
  - best updated at e+2.
- Final beat accepted at edge eN:
  - BEST_* final and DONE=1 after edge eN+2;
  - DONE=0 and BUSY=0 after edge eN+3.
- Throughput is one block per cycle with arbitrary gaps between beats.
- RST at any point returns the block to its reset values on that edge. This includes mid-evaluation.

## Structure
- Shared package holds:
  - pixel width 8, block pixels 16, SAD width 12, mode width 6;
  - NUM_MODES default 35;
  - state enumeration IDLE/ACCUM/FLUSH.
- Sub-module sad4x4_tree: 2-stage pipelined abs-diff plus adder tree, carrying the valid and mode tags alongside the data.
- The top level holds the FSM, beat counter, ORIG_BLK latch and minimum tracker.

## Test plan
- Reset: assert RST 2 cycles -> BUSY=0, DONE=0, BEST_MODE=0, BEST_SAD=0. PRED_VALID pulses while IDLE -> no state change and no DONE.
- Minimum search:
  - Stimulus: ORIG all 80; modes 0..34 back-to-back, mode m block all 60+m.
  - Response: DONE exactly 2 edges after the last beat; BEST_MODE=20, BEST_SAD=0.
- Tie:
  - Stimulus: ORIG all 0; all 35 blocks all 5, modes sent in order 7,0,1,...
  - Response: BEST_MODE=7, BEST_SAD=80.
- Width extreme: ORIG all 0, every block all 255 -> BEST_SAD=4080, BEST_MODE = first mode sent.
- Gapped input: minimum-search stimulus with random 0-3 idle cycles between beats -> same result; DONE 2 edges after the 35th beat; beats sent after DONE are ignored.
- Abort:
  - Stimulus: START, 10 beats with SAD 0 (pred equal to orig), then START with new ORIG all 200 and 35 beats where only mode 3 equals 200.
  - Response: exactly one DONE; BEST_MODE=3, BEST_SAD=0.
  - RST asserted mid-ACCUM -> reset values and no DONE.
